// File: rtl/fir_tap_loader_if.sv
// Host/FIR-side bus of the FIR coefficient loader: tap-burst write port,
// frame boundary strobe, coefficient read port and load status.
interface fir_tap_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              frame_sync;
  logic              tap_wr_cmd;
  logic [31:0]       tap_wr_addr;
  logic              tap_wr_vld;
  logic [31:0]       tap_wr_data;
  logic [ADDR_W-1:0] coef_rd_addr;
  logic [31:0]       coef_rd_data;
  logic              active_bank;
  logic              swap_pend;
  logic              load_done;
  logic              load_err;
  logic [15:0]       load_cnt;
  logic [15:0]       err_cnt;

  modport master (
    output frame_sync, tap_wr_cmd, tap_wr_addr, tap_wr_vld, tap_wr_data, coef_rd_addr,
    input  coef_rd_data, active_bank, swap_pend, load_done, load_err, load_cnt, err_cnt
  );

  modport slave (
    input  frame_sync, tap_wr_cmd, tap_wr_addr, tap_wr_vld, tap_wr_data, coef_rd_addr,
    output coef_rd_data, active_bank, swap_pend, load_done, load_err, load_cnt, err_cnt
  );
endinterface

// File: rtl/fir_tap_loader.sv
// Double-buffered FIR coefficient store: bursts fill the shadow bank, a verified
// complete load is swapped in at the next frame boundary.
module fir_tap_loader #(
  parameter int unsigned TAP_NUM = 64,
  parameter int unsigned ADDR_W  = 10
) (
  input logic             clk_100m,
  input logic             rst_100m,
  fir_tap_loader_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(TAP_NUM + 1);
  localparam int unsigned IDX_W = $clog2(TAP_NUM);
  localparam logic [31:0] BIAS_TAG = 32'hFFFF_0000;

  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_n;
  logic             ovf, ovf_n;
  logic             active_bank, active_bank_n;
  logic             swap_pend, swap_pend_n;
  logic             load_done, load_done_n;
  logic             load_err, load_err_n;
  logic [15:0]      load_cnt, load_cnt_n;
  logic [15:0]      err_cnt, err_cnt_n;
  logic             cmd_prev;
  logic [31:0]      coef_rd_data;
  logic             wr_en_c;
  logic             start_c;
  logic             fall_c;

  logic [31:0] bank0 [TAP_NUM];
  logic [31:0] bank1 [TAP_NUM];

  // cmd_prev keeps tracking through reset so a burst still in flight is not a new start
  always_ff @(posedge clk_100m) cmd_prev <= bus.tap_wr_cmd;

  assign start_c = bus.tap_wr_cmd & ~cmd_prev & (bus.tap_wr_addr != BIAS_TAG);
  assign fall_c  = ~bus.tap_wr_cmd & cmd_prev;

  always_ff @(posedge clk_100m) begin
    if (rst_100m) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      ovf         <= 1'b0;
      active_bank <= 1'b0;
      swap_pend   <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      load_cnt    <= '0;
      err_cnt     <= '0;
    end else begin
      state       <= state_n;
      beat_cnt    <= beat_cnt_n;
      ovf         <= ovf_n;
      active_bank <= active_bank_n;
      swap_pend   <= swap_pend_n;
      load_done   <= load_done_n;
      load_err    <= load_err_n;
      load_cnt    <= load_cnt_n;
      err_cnt     <= err_cnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    beat_cnt_n    = beat_cnt;
    ovf_n         = ovf;
    active_bank_n = active_bank;
    swap_pend_n   = swap_pend;
    load_done_n   = 1'b0;
    load_err_n    = 1'b0;
    load_cnt_n    = load_cnt;
    err_cnt_n     = err_cnt;
    wr_en_c       = 1'b0;
    case (state)
      IDLE: begin
        if (start_c) begin
          state_n    = LOAD;
          beat_cnt_n = '0;
          ovf_n      = 1'b0;
          swap_pend_n = 1'b0;
        end
      end
      LOAD: begin
        if (fall_c) begin
          if ((32'(beat_cnt) == TAP_NUM) && !ovf) begin
            state_n     = PEND;
            swap_pend_n = 1'b1;
          end else begin
            state_n    = IDLE;
            load_err_n = 1'b1;
            err_cnt_n  = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
          end
        end else if (bus.tap_wr_vld) begin
          if (32'(beat_cnt) < TAP_NUM) begin
            wr_en_c    = 1'b1;
            beat_cnt_n = beat_cnt + CNT_W'(1);
          end else begin
            ovf_n = 1'b1;
          end
        end
      end
      PEND: begin
        // swap first, so a coincident new burst targets the freshly retired bank
        if (bus.frame_sync) begin
          active_bank_n = ~active_bank;
          load_done_n   = 1'b1;
          load_cnt_n    = (load_cnt == 16'hFFFF) ? load_cnt : load_cnt + 16'd1;
          swap_pend_n   = 1'b0;
          state_n       = IDLE;
        end
        if (start_c) begin
          state_n     = LOAD;
          beat_cnt_n  = '0;
          ovf_n       = 1'b0;
          swap_pend_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // shadow bank write; bank contents survive reset
  always_ff @(posedge clk_100m) begin
    if (!rst_100m && wr_en_c) begin
      if (active_bank) bank0[IDX_W'(beat_cnt)] <= bus.tap_wr_data;
      else             bank1[IDX_W'(beat_cnt)] <= bus.tap_wr_data;
    end
  end

  always_ff @(posedge clk_100m) begin
    if (rst_100m) begin
      coef_rd_data <= '0;
    end else if (32'(bus.coef_rd_addr) >= TAP_NUM) begin
      coef_rd_data <= '0;
    end else if (active_bank) begin
      coef_rd_data <= bank1[IDX_W'(bus.coef_rd_addr)];
    end else begin
      coef_rd_data <= bank0[IDX_W'(bus.coef_rd_addr)];
    end
  end

  assign bus.coef_rd_data = coef_rd_data;
  assign bus.active_bank  = active_bank;
  assign bus.swap_pend    = swap_pend;
  assign bus.load_done    = load_done;
  assign bus.load_err     = load_err;
  assign bus.load_cnt     = load_cnt;
  assign bus.err_cnt      = err_cnt;
endmodule

// File: tb/tb_fir_tap_loader.sv
// Scoreboard bench for fir_tap_loader (TAP_NUM=8): a bank/counter model predicts
// pulses and read data; a negedge monitor pops and compares.
module tb_fir_tap_loader;
  localparam int unsigned TAP = 8;
  localparam logic [31:0] BIAS = 32'hFFFF_0000;

  logic clk = 1'b0;
  logic rst;
  logic rd_req = 1'b0;
  logic rd_q = 1'b0;

  always #5 clk = ~clk;

  fir_tap_loader_if #(.ADDR_W(10)) bus ();

  fir_tap_loader #(.TAP_NUM(TAP), .ADDR_W(10)) dut (
    .clk_100m(clk),
    .rst_100m(rst),
    .bus     (bus)
  );

  typedef struct {
    bit          is_err;
    logic        bank;
    logic [15:0] lc;
    logic [15:0] ec;
  } ev_t;

  ev_t         evq [$];
  logic [31:0] rdq [$];

  int          n_tests = 0;
  int          n_fail  = 0;

  // reference model
  logic [31:0] m_bank [2][TAP];
  bit          m_active;
  int          m_load;
  int          m_err;
  bit          m_pend;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void m_swap();
    ev_t e;
    m_active = ~m_active;
    m_load   = (m_load < 65535) ? m_load + 1 : m_load;
    m_pend   = 1'b0;
    e.is_err = 1'b0; e.bank = m_active; e.lc = 16'(m_load); e.ec = 16'(m_err);
    evq.push_back(e);
  endfunction

  always @(posedge clk) rd_q <= rd_req;

  // monitor: every pulse and every read response must match the head of its queue
  always @(negedge clk) begin
    ev_t e;
    logic [31:0] exp_rd;
    if (bus.load_done || bus.load_err) begin
      if (evq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_pulse: load_done=%0b load_err=%0b expected none (t=%0t)",
                 bus.load_done, bus.load_err, $time);
      end else begin
        e = evq.pop_front();
        chk("pulse_kind", 32'({bus.load_done, bus.load_err}), e.is_err ? 32'd1 : 32'd2);
        chk("pulse_active_bank", 32'(bus.active_bank), 32'(e.bank));
        chk("pulse_load_cnt", 32'(bus.load_cnt), 32'(e.lc));
        chk("pulse_err_cnt", 32'(bus.err_cnt), 32'(e.ec));
      end
    end
    if (rd_q) begin
      if (rdq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL read_queue: got %h expected no read", bus.coef_rd_data);
      end else begin
        exp_rd = rdq.pop_front();
        chk("coef_rd_data", bus.coef_rd_data, exp_rd);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic burst(input logic [31:0] tag, input int n, input bit seq,
                       input bit fs_at_start, input bit fall_beat);
    logic [31:0] d [$];
    ev_t         e;
    bit          sh;
    for (int i = 0; i < n; i++) d.push_back(seq ? 32'(i + 1) : $urandom);
    if (fs_at_start && m_pend) m_swap();
    if (tag != BIAS) begin
      m_pend = 1'b0;
      sh = ~m_active;
      for (int i = 0; i < n && i < int'(TAP); i++) m_bank[sh][i] = d[i];
      if (n == int'(TAP)) m_pend = 1'b1;
      else begin
        m_err = (m_err < 65535) ? m_err + 1 : m_err;
        e.is_err = 1'b1; e.bank = m_active; e.lc = 16'(m_load); e.ec = 16'(m_err);
        evq.push_back(e);
      end
    end
    tick();
    bus.tap_wr_cmd = 1'b1; bus.tap_wr_addr = tag; bus.frame_sync = fs_at_start; bus.tap_wr_vld = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      bus.frame_sync = 1'b0; bus.tap_wr_vld = 1'b0; bus.tap_wr_addr = $urandom;
      if ($urandom_range(0, 3) == 0) tick();
      bus.tap_wr_vld = 1'b1; bus.tap_wr_data = d[i];
    end
    tick();
    bus.tap_wr_cmd = 1'b0; bus.tap_wr_vld = fall_beat; bus.tap_wr_data = $urandom;
    tick();
    bus.tap_wr_vld = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk);
    chk("swap_pend_before_frame", 32'(bus.swap_pend), 32'(m_pend));
    tick();
    bus.frame_sync = 1'b1;
    if (m_pend) m_swap();
    tick();
    bus.frame_sync = 1'b0;
    @(negedge clk);
    chk("swap_pend_after_frame", 32'(bus.swap_pend), 32'd0);
    chk("active_bank_after_frame", 32'(bus.active_bank), 32'(m_active));
  endtask

  task automatic rd(input int idx);
    tick();
    bus.coef_rd_addr = 10'(idx);
    rd_req = 1'b1;
    if (idx < int'(TAP)) rdq.push_back(m_bank[m_active][idx]);
    else                 rdq.push_back(32'd0);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic cmp_banks();
    @(negedge clk);
    for (int i = 0; i < int'(TAP); i++) begin
      chk("bank0", dut.bank0[i], m_bank[0][i]);
      chk("bank1", dut.bank1[i], m_bank[1][i]);
    end
    chk("load_cnt", 32'(bus.load_cnt), 32'(m_load));
    chk("err_cnt", 32'(bus.err_cnt), 32'(m_err));
    chk("active_bank", 32'(bus.active_bank), 32'(m_active));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_active_bank", 32'(bus.active_bank), 32'd0);
    chk("rst_swap_pend", 32'(bus.swap_pend), 32'd0);
    chk("rst_load_done", 32'(bus.load_done), 32'd0);
    chk("rst_load_err", 32'(bus.load_err), 32'd0);
    chk("rst_load_cnt", 32'(bus.load_cnt), 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("rst_coef_rd_data", bus.coef_rd_data, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int r;
    logic [31:0] tag;
    rst = 1'b1;
    bus.frame_sync = 1'b0; bus.tap_wr_cmd = 1'b0; bus.tap_wr_addr = '0;
    bus.tap_wr_vld = 1'b0; bus.tap_wr_data = '0; bus.coef_rd_addr = '0;
    m_active = 1'b0; m_load = 0; m_err = 0; m_pend = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk_reset_outputs();
    tick();
    rst = 1'b0;

    // complete load 1..8, swap five cycles after cmd falls
    burst(32'h0000_1000, 8, 1'b1, 1'b0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("swap_pend_waiting", 32'(bus.swap_pend), 32'd1);
    end
    frame();
    chk("first_load_cnt", 32'(bus.load_cnt), 32'd1);
    rd(3);
    burst(32'h0000_2000, 8, 1'b0, 1'b0, 1'b1);
    frame();
    cmp_banks();

    // short burst: rejected, active bank untouched
    burst(32'h0000_3000, 7, 1'b0, 1'b0, 1'b0);
    frame();
    for (int i = 0; i < int'(TAP); i++) rd(i);
    cmp_banks();

    // long burst: rejected, shadow keeps the first eight beats
    burst(32'h0000_4000, 9, 1'b1, 1'b0, 1'b0);
    cmp_banks();

    // bias-tagged burst is ignored entirely
    burst(BIAS, 8, 1'b0, 1'b0, 1'b1);
    cmp_banks();

    // swap coincident with new burst start
    burst(32'h0000_5000, 8, 1'b0, 1'b0, 1'b0);
    burst(32'h0000_6000, 8, 1'b0, 1'b1, 1'b0);
    frame();
    cmp_banks();

    // new burst without frame_sync drops the pending load
    burst(32'h0000_7000, 8, 1'b0, 1'b0, 1'b0);
    burst(32'h0000_8000, 7, 1'b0, 1'b0, 1'b0);
    frame();
    rd(8); rd(1023);
    cmp_banks();

    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 9);
      n = (r < 6) ? 8 : ((r < 8) ? 7 : 9);
      tag = ($urandom_range(0, 7) == 0) ? BIAS : ($urandom & 32'h7FFF_FFFF);
      burst(tag, n, 1'b0, m_pend && ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) frame();
      repeat (2) rd($urandom_range(0, 9));
    end
    cmp_banks();

    // reset in the middle of a load, cmd held high across it
    tick();
    bus.tap_wr_cmd = 1'b1; bus.tap_wr_addr = 32'h0000_9000;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.tap_wr_vld = 1'b1; bus.tap_wr_data = $urandom;
      m_bank[~m_active][i] = bus.tap_wr_data;
    end
    tick();
    bus.tap_wr_vld = 1'b0; rst = 1'b1;
    tick();
    m_active = 1'b0; m_load = 0; m_err = 0; m_pend = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0; bus.tap_wr_vld = 1'b1; bus.tap_wr_data = $urandom;
    tick();
    tick();
    bus.tap_wr_cmd = 1'b0; bus.tap_wr_vld = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("post_rst_swap_pend", 32'(bus.swap_pend), 32'd0);
    cmp_banks();
    burst(32'h0000_A000, 8, 1'b0, 1'b0, 1'b0);
    frame();
    rd(5);
    cmp_banks();

    repeat (5) tick();
    chk("event_queue_empty", 32'(evq.size()), 32'd0);
    chk("read_queue_empty", 32'(rdq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
